// File: rtl/trace_pkg.sv
// Shared definitions for the branch trace buffer: RISC-V control-transfer
// opcodes, record kind encodings and the packed trace record layout.
package trace_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'd0,
    KIND_JAL    = 2'd1,
    KIND_JALR   = 2'd2,
    KIND_OTHER  = 2'd3
  } kind_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    kind_e       kind;
    logic        taken;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  function automatic kind_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_BRANCH: return KIND_BRANCH;
      OPC_JAL:    return KIND_JAL;
      OPC_JALR:   return KIND_JALR;
      default:    return KIND_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with packed storage. The caller must not push
// while full unless it pops in the same cycle; clear overrides push and pop.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int WIDTH = REC_W,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/branch_trace_buffer.sv
// Captures retired branch/jump records into a FIFO for a trace consumer,
// dropping and counting records that arrive while the FIFO is full.
module branch_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH            = 8,
  parameter bit RECORD_NOT_TAKEN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_is_branch_jump,
  input  logic [6:0]             in_opcode,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_next_pc,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_target,
  output logic [1:0]             out_kind,
  output logic                   out_taken,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_count
);

  kind_e            kind;
  logic             taken;
  logic             push;
  logic             pop;
  logic             push_acc;
  logic             full;
  logic             empty;
  trace_rec_t       wr_rec;
  trace_rec_t       head;
  logic [REC_W-1:0] head_raw;
  logic [15:0]      drop_count_q, drop_count_d;

  always_comb begin
    kind  = classify(in_opcode);
    // Unconditional jumps always redirect, so the PC compare is bypassed.
    taken = (kind == KIND_JAL || kind == KIND_JALR) ? 1'b1
                                                    : (in_next_pc != in_pc + 32'd4);
    push     = in_valid & in_is_branch_jump & (RECORD_NOT_TAKEN | taken);
    pop      = out_valid & out_ready;
    push_acc = push & (~full | pop);
    wr_rec   = '{pc: in_pc, target: in_next_pc, kind: kind, taken: taken};
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (clear) begin
      drop_count_d = '0;
    end else if (push && !push_acc && drop_count_q != 16'hFFFF) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  trace_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push_acc),
    .pop   (pop),
    .wdata (wr_rec),
    .rdata (head_raw),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    head       = trace_rec_t'(head_raw);
    out_valid  = ~empty;
    out_pc     = out_valid ? head.pc     : 32'd0;
    out_target = out_valid ? head.target : 32'd0;
    out_kind   = out_valid ? head.kind   : 2'd0;
    out_taken  = out_valid ? head.taken  : 1'b0;
    drop_count = drop_count_q;
  end

endmodule

// File: tb/tb_branch_trace_buffer.sv
// Randomized and directed bench for branch_trace_buffer, with one instance
// recording not-taken branches and one recording taken transfers only.
module tb_branch_trace_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_is_branch_jump, out_ready;
  logic [6:0]  in_opcode;
  logic [31:0] in_pc, in_next_pc;

  logic        out_valid, out_taken;
  logic [31:0] out_pc, out_target;
  logic [1:0]  out_kind;
  logic [3:0]  count;
  logic [15:0] drop_count;

  logic        z_out_valid, z_out_taken;
  logic [31:0] z_out_pc, z_out_target;
  logic [1:0]  z_out_kind;
  logic [3:0]  z_count;
  logic [15:0] z_drop_count;

  int n_vec = 0;
  int n_err = 0;

  logic [66:0] q1[$];
  logic [66:0] q0[$];
  int          drop1, drop0;

  always #5 clk = ~clk;

  branch_trace_buffer #(.DEPTH(DEPTH), .RECORD_NOT_TAKEN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_is_branch_jump(in_is_branch_jump),
    .in_opcode(in_opcode), .in_pc(in_pc), .in_next_pc(in_next_pc), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_target(out_target),
    .out_kind(out_kind), .out_taken(out_taken), .count(count), .drop_count(drop_count)
  );

  branch_trace_buffer #(.DEPTH(DEPTH), .RECORD_NOT_TAKEN(1'b0)) dut_taken_only (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_is_branch_jump(in_is_branch_jump),
    .in_opcode(in_opcode), .in_pc(in_pc), .in_next_pc(in_next_pc), .clear(clear),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_pc(z_out_pc), .out_target(z_out_target),
    .out_kind(z_out_kind), .out_taken(z_out_taken), .count(z_count), .drop_count(z_drop_count)
  );

  task automatic check_eq(input string tag, input logic [66:0] act, input logic [66:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs held before it.
  task automatic model_edge();
    logic [1:0]  k;
    logic        tk, cand, pop1, pop0, acc1, acc0;
    logic [66:0] r;
    case (in_opcode)
      7'h63:   k = 2'd0;
      7'h6F:   k = 2'd1;
      7'h67:   k = 2'd2;
      default: k = 2'd3;
    endcase
    tk   = (k == 2'd1 || k == 2'd2) ? 1'b1 : (in_next_pc != in_pc + 32'd4);
    r    = {in_pc, in_next_pc, k, tk};
    cand = in_valid && in_is_branch_jump;
    if (rst || clear) begin
      q1.delete();
      q0.delete();
      drop1 = 0;
      drop0 = 0;
    end else begin
      pop1 = (q1.size() > 0) && out_ready;
      pop0 = (q0.size() > 0) && out_ready;
      acc1 = (q1.size() < DEPTH) || pop1;
      acc0 = (q0.size() < DEPTH) || pop0;
      if (pop1) void'(q1.pop_front());
      if (pop0) void'(q0.pop_front());
      if (cand) begin
        if (acc1) q1.push_back(r);
        else if (drop1 < 65535) drop1++;
      end
      if (cand && tk) begin
        if (acc0) q0.push_back(r);
        else if (drop0 < 65535) drop0++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [66:0] h1, h0;
    h1 = (q1.size() > 0) ? q1[0] : 67'd0;
    h0 = (q0.size() > 0) ? q0[0] : 67'd0;
    check_eq("valid", out_valid, q1.size() != 0);
    check_eq("count", count, q1.size());
    check_eq("drop", drop_count, drop1);
    check_eq("head", {out_pc, out_target, out_kind, out_taken}, h1);
    check_eq("tonly_valid", z_out_valid, q0.size() != 0);
    check_eq("tonly_count", z_count, q0.size());
    check_eq("tonly_drop", z_drop_count, drop0);
    check_eq("tonly_head", {z_out_pc, z_out_target, z_out_kind, z_out_taken}, h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic bj, input logic [6:0] op,
                       input logic [31:0] pc, input logic [31:0] nx);
    in_valid          = v;
    in_is_branch_jump = bj;
    in_opcode         = op;
    in_pc             = pc;
    in_next_pc        = nx;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 7'h00, 32'd0, 32'd0);
  endtask

  initial begin
    logic [66:0] held;
    logic [6:0]  ops [4];
    ops[0] = 7'h63; ops[1] = 7'h6F; ops[2] = 7'h67; ops[3] = 7'h13;

    rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
    idle();
    tick();
    tick();
    check_eq("rst_outputs", {out_valid, out_pc, out_target, out_kind, out_taken}, 68'd0);
    check_eq("rst_counts", {count, drop_count}, 20'd0);
    rst = 1'b0;

    // Single jal, then pop it.
    drive(1'b1, 1'b1, 7'h6F, 32'h100, 32'h200);
    tick();
    check_eq("jal_head", {out_valid, out_pc, out_target, out_kind, out_taken},
             {1'b1, 32'h100, 32'h200, 2'd1, 1'b1});
    idle();
    out_ready = 1'b1;
    tick();
    check_eq("jal_popped", {out_valid, count}, 5'd0);

    // Not-taken branch, then the wrap-around case while popping.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 7'h63, 32'h40, 32'h44);
    tick();
    check_eq("nt_head", {out_pc, out_target, out_kind, out_taken}, {32'h40, 32'h44, 2'd0, 1'b0});
    check_eq("nt_taken_only", z_count, 4'd0);
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 7'h63, 32'hFFFF_FFFC, 32'h0);
    tick();
    check_eq("wrap_head", {out_pc, out_target, out_kind, out_taken},
             {32'hFFFF_FFFC, 32'h0, 2'd0, 1'b0});
    check_eq("wrap_taken_only", z_count, 4'd0);
    idle();
    tick();

    // Overflow: 10 pushes into 8 entries, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 7'h6F, 32'h1000 + 32'(i * 16), 32'h2000);
      tick();
    end
    check_eq("ovf_count", count, 4'd8);
    check_eq("ovf_drop", drop_count, 16'd2);
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("ovf_order", out_pc, 32'h1000 + 32'(i * 16));
      tick();
    end
    check_eq("ovf_empty", count, 4'd0);

    // Full with simultaneous push and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 7'h67, 32'h3000 + 32'(i * 4), 32'h5000);
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 7'h67, 32'h3100, 32'h5000);
    tick();
    check_eq("full_pp_count", count, 4'd8);
    check_eq("full_pp_drop", drop_count, 16'd2);
    idle();
    for (int i = 0; i < 8; i++) tick();

    // Backpressure: head held while pushes continue.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 7'h63, 32'h600, 32'h700);
    tick();
    held = {out_pc, out_target, out_kind, out_taken};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 7'h6F, 32'h800 + 32'(i * 4), 32'h900);
      tick();
      check_eq("bp_head", {out_pc, out_target, out_kind, out_taken}, held);
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Clear during traffic: reach count=5, drop_count=3 first.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b1, 7'h6F, 32'hA000 + 32'(i * 4), 32'hB000);
      tick();
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("pre_clear_count", count, 4'd5);
    check_eq("pre_clear_drop", drop_count, 16'd3);
    clear = 1'b1;
    drive(1'b1, 1'b1, 7'h6F, 32'hC000, 32'hD000);
    tick();
    check_eq("clear_state", {out_valid, count, drop_count}, 21'd0);
    clear = 1'b0;
    idle();

    // Randomized traffic with phases of heavy backpressure.
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] pc;
      rst   = ($urandom % 300) == 0;
      clear = ($urandom % 150) == 0;
      pc    = $urandom & 32'hFFFF_FFFC;
      if ($urandom % 50 == 0) pc = 32'hFFFF_FFFC;
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, ops[$urandom % 4], pc,
            ($urandom % 2) ? pc + 32'd4 : $urandom);
      out_ready = ((c / 250) % 2) ? (($urandom % 5) == 0) : (($urandom % 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
